alu_issue_stage: RTL

//  Upstream neighbour of the 4-bit-opcode ALU (ops 0..9: add,sub,and,or,xor,sll,srl,sra,ugt,sgt).

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_issue_stage_if.sv | 29 ++
 rtl/alu_issue_decode.sv | 99 +++++++++
 rtl/alu_issue_stage.sv | 100 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and the decoded-operand bundle for the ALU issue stage.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_UGT = 4'd8;
  localparam logic [3:0] ALU_SGT = 4'd9;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_SLTIU = 6'h0b;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_XORI  = 6'h0e;
  localparam logic [5:0] OPC_LUI   = 6'h0f;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        op;
    logic [REG_W-1:0]  rd;
    logic              we;
    logic              illegal;
  } issue_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction-in / ALU-operands-out handshake bundle of the issue stage.
interface alu_issue_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [DW-1:0] in_rs_data;
  logic [DW-1:0] in_rt_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_op;
  logic [RW-1:0] out_rd;
  logic          out_we;
  logic          out_illegal;

  modport master (
    output in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, out_rd, out_we, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode: instruction plus rs/rt data -> ALU operand bundle.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  output issue_t            dec_o
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [REG_W-1:0]  rt_idx;
  logic [REG_W-1:0]  rd_idx;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic              legal;
  issue_t            raw;

  assign opcode   = instr_i[31:26];
  assign rt_idx   = instr_i[20:16];
  assign rd_idx   = instr_i[15:11];
  assign shamt    = instr_i[10:6];
  assign funct    = instr_i[5:0];
  assign imm      = instr_i[15:0];
  assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm};

  // rs index only matters to the forwarding muxes in the top.
  logic unused_rs_idx;
  assign unused_rs_idx = ^instr_i[25:21];

  always_comb begin
    raw   = '0;
    legal = 1'b1;
    if (opcode == OPC_RTYPE) begin
      raw.rd = rd_idx;
      raw.a  = rs_data_i;
      raw.b  = rt_data_i;
      case (funct)
        FN_ADDU: raw.op = ALU_ADD;
        FN_SUBU: raw.op = ALU_SUB;
        FN_AND:  raw.op = ALU_AND;
        FN_OR:   raw.op = ALU_OR;
        FN_XOR:  raw.op = ALU_XOR;
        FN_SLLV: begin raw.op = ALU_SLL; raw.a = rt_data_i; raw.b = rs_data_i; end
        FN_SRLV: begin raw.op = ALU_SRL; raw.a = rt_data_i; raw.b = rs_data_i; end
        FN_SRAV: begin raw.op = ALU_SRA; raw.a = rt_data_i; raw.b = rs_data_i; end
        FN_SLL: begin
          raw.op = ALU_SLL;
          raw.a  = rt_data_i;
          raw.b  = {{(DATA_W-5){1'b0}}, shamt};
        end
        FN_SRL: begin
          raw.op = ALU_SRL;
          raw.a  = rt_data_i;
          raw.b  = {{(DATA_W-5){1'b0}}, shamt};
        end
        FN_SRA: begin
          raw.op = ALU_SRA;
          raw.a  = rt_data_i;
          raw.b  = {{(DATA_W-5){1'b0}}, shamt};
        end
        // The ALU only computes A>B, so set-less-than swaps its operands.
        FN_SLT:  begin raw.op = ALU_SGT; raw.a = rt_data_i; raw.b = rs_data_i; end
        FN_SLTU: begin raw.op = ALU_UGT; raw.a = rt_data_i; raw.b = rs_data_i; end
        default: legal = 1'b0;
      endcase
    end else begin
      raw.rd = rt_idx;
      raw.a  = rs_data_i;
      case (opcode)
        OPC_ADDIU: begin raw.op = ALU_ADD; raw.b = imm_sext; end
        OPC_ANDI:  begin raw.op = ALU_AND; raw.b = imm_zext; end
        OPC_ORI:   begin raw.op = ALU_OR;  raw.b = imm_zext; end
        OPC_XORI:  begin raw.op = ALU_XOR; raw.b = imm_zext; end
        OPC_LUI: begin
          raw.op = ALU_SLL;
          raw.a  = imm_zext;
          raw.b  = DATA_W'(16);
        end
        OPC_SLTI:  begin raw.op = ALU_SGT; raw.a = imm_sext; raw.b = rs_data_i; end
        OPC_SLTIU: begin raw.op = ALU_UGT; raw.a = imm_sext; raw.b = rs_data_i; end
        default:   legal = 1'b0;
      endcase
    end

    if (legal) begin
      dec_o    = raw;
      dec_o.we = (raw.rd != '0);
    end else begin
      dec_o         = '0;
      dec_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: optional operand forwarding, decode, one-entry valid/ready register.
// Build option: define ALU_ISSUE_FORWARD_EN to bypass EX/MEM results onto rs/rt.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned RW = REG_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          fwd_ex_we,
  input  logic [RW-1:0] fwd_ex_rd,
  input  logic [DW-1:0] fwd_ex_data,
  input  logic          fwd_mem_we,
  input  logic [RW-1:0] fwd_mem_rd,
  input  logic [DW-1:0] fwd_mem_data,
  alu_issue_stage_if.slave bus
);

  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;

`ifdef ALU_ISSUE_FORWARD_EN
  logic [RW-1:0] rs_idx;
  logic [RW-1:0] rt_idx;

  assign rs_idx = RW'(bus.in_instr[25:21]);
  assign rt_idx = RW'(bus.in_instr[20:16]);

  // EX is the younger producer, so it takes precedence over MEM; $0 is never bypassed.
  always_comb begin
    rs_val = bus.in_rs_data;
    if (rs_idx != '0 && fwd_ex_we && fwd_ex_rd == rs_idx) begin
      rs_val = fwd_ex_data;
    end else if (rs_idx != '0 && fwd_mem_we && fwd_mem_rd == rs_idx) begin
      rs_val = fwd_mem_data;
    end
    rt_val = bus.in_rt_data;
    if (rt_idx != '0 && fwd_ex_we && fwd_ex_rd == rt_idx) begin
      rt_val = fwd_ex_data;
    end else if (rt_idx != '0 && fwd_mem_we && fwd_mem_rd == rt_idx) begin
      rt_val = fwd_mem_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ex_we, fwd_ex_rd, fwd_ex_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data};
  assign rs_val = bus.in_rs_data;
  assign rt_val = bus.in_rt_data;
`endif

  issue_t dec;

  alu_issue_decode u_decode (
    .instr_i   (bus.in_instr),
    .rs_data_i (rs_val),
    .rt_data_i (rt_val),
    .dec_o     (dec)
  );

  logic   valid_q, valid_d;
  issue_t entry_q, entry_d;
  logic   load;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      entry_d = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.alu_a       = entry_q.a;
  assign bus.alu_b       = entry_q.b;
  assign bus.alu_op      = entry_q.op;
  assign bus.out_rd      = entry_q.rd;
  assign bus.out_we      = entry_q.we;
  assign bus.out_illegal = entry_q.illegal;

endmodule
